// File: rtl/ame_pkg.sv
// rtl/ame_pkg.sv - shared types and widths for the AME operand code path
package ame_pkg;

    localparam int AME_OP_W  = 8;
    localparam int AME_POS_W = 3;

    // Leading-one operand code: nonzero flag, leading-one position, bit below it
    typedef struct packed {
        logic                 nz;
        logic [AME_POS_W-1:0] pos;
        logic                 sub;
    } ame_code_t;

endpackage

// File: rtl/ame_pri_dec_expand.sv
// rtl/ame_pri_dec_expand.sv - combinational code-to-operand expansion (optional AME_PRI_DEC_ROUND_EN)
module ame_pri_dec_expand
    import ame_pkg::*;
(
    input  logic [AME_OP_W-1:0] pos_oh,
    input  logic                sub,
    input  logic                zero,
    output logic [AME_OP_W-1:0] value
);

    logic [AME_OP_W-1:0] below;
    logic [AME_OP_W-1:0] tail;

    // Leading one, the sub bit one place below it, and optionally a midpoint bit two below
    always_comb begin
        below = sub ? (pos_oh >> 1) : '0;
`ifdef AME_PRI_DEC_ROUND_EN
        tail  = pos_oh >> 2;
`else
        tail  = '0;
`endif
        value = zero ? '0 : (pos_oh | below | tail);
    end

endmodule

// File: rtl/ame_pri_dec.sv
// rtl/ame_pri_dec.sv - two-stage streaming leading-one operand decoder with frame zero count and error flag
module ame_pri_dec
    import ame_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [4:0]          in_code_i,
    input  logic                in_last_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [AME_OP_W-1:0] out_data_o,
    output logic                out_last_o,
    output logic [CNT_W-1:0]    zero_cnt_o,
    output logic                err_o
);

    ame_code_t           code;
    logic                code_zero;
    logic                code_bad;
    logic                in_fire;

    logic                s1_valid;
    logic [AME_OP_W-1:0] s1_pos_oh;
    logic                s1_sub;
    logic                s1_zero;
    logic                s1_last;

    logic                s2_take;
    logic                s2_free;
    logic                s1_advance;
    logic [AME_OP_W-1:0] s2_value;
    logic [CNT_W-1:0]    cnt_base;
    logic [CNT_W-1:0]    cnt_next;

    assign code      = ame_code_t'(in_code_i);
    assign code_zero = !code.nz;
    assign code_bad  = !code.nz && ((code.pos != '0) || code.sub);

    assign s2_take    = out_valid_o && out_ready_i;
    assign s2_free    = !out_valid_o || out_ready_i;
    assign s1_advance = s1_valid && s2_free;
    assign in_ready_o = !s1_valid || s1_advance;
    assign in_fire    = in_valid_i && in_ready_o;

    // A frame-closing beat leaving this cycle makes the incoming beat start a fresh count
    always_comb begin
        cnt_base = (s2_take && out_last_o) ? '0 : zero_cnt_o;
        cnt_next = (s1_zero && (cnt_base != '1)) ? cnt_base + CNT_W'(1) : cnt_base;
    end

    ame_pri_dec_expand u_expand (
        .pos_oh (s1_pos_oh),
        .sub    (s1_sub),
        .zero   (s1_zero),
        .value  (s2_value)
    );

    // Stage 1: capture one-hot position, sub bit, zero flag and frame end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid  <= 1'b0;
            s1_pos_oh <= '0;
            s1_sub    <= 1'b0;
            s1_zero   <= 1'b0;
            s1_last   <= 1'b0;
        end else if (in_ready_o) begin
            s1_valid <= in_valid_i;
            if (in_valid_i) begin
                s1_pos_oh <= AME_OP_W'(1) << code.pos;
                s1_sub    <= code.sub;
                s1_zero   <= code_zero;
                s1_last   <= in_last_i;
            end
        end
    end

    // Stage 2: form the operand and running zero count, held until the beat transfers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
            zero_cnt_o  <= '0;
        end else if (s2_free) begin
            out_valid_o <= s1_valid;
            if (s1_valid) begin
                out_data_o <= s2_value;
                out_last_o <= s1_last;
                zero_cnt_o <= cnt_next;
            end else if (s2_take && out_last_o) begin
                zero_cnt_o <= '0;
            end
        end
    end

    // Sticky malformed-code flag, set on input acceptance regardless of output stalls
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (in_fire && code_bad) begin
            err_o <= 1'b1;
        end
    end

endmodule
